// File: rtl/series_result_unpacker_pkg.sv
// Shared definitions for the series-adder result unpacker: FSM encoding and
// word/byte geometry helpers.
package series_result_unpacker_pkg;

    localparam int PKG_DATA_W = 32;

    function automatic int bytes_per_word(input int w);
        return w / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(PKG_DATA_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/series_result_unpacker.sv
// Unpacks framed little-endian result words into a byte stream with
// first/last markers, valid/ready on both sides, and framing-error reporting.
module series_result_unpacker
    import series_result_unpacker_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [CNT_W-1:0]  num_bytes_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              word_first,
    input  logic              word_last,
    input  logic              word_vld,
    output logic              word_rdy,
    output logic [7:0]        byte_o,
    output logic              byte_first,
    output logic              byte_last,
    output logic              byte_vld,
    input  logic              byte_rdy,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int BPW  = bytes_per_word(DATA_W);
    localparam int WC_W = $clog2(BPW + 1);
    localparam logic [CNT_W-1:0] BPW_C = CNT_W'(BPW);

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  sreg;
    logic [WC_W-1:0]    wcnt;
    logic [CNT_W-1:0]   remaining;
    logic               force_last;

    logic               accept;
    logic               pop;
    logic               word_end;
    logic               frame_end;
    logic               eff_idle;
    logic               start;
    logic               cont;
    logic               kill;
    logic               load;
    logic               forced;
    logic               err_now;
    logic [CNT_W-1:0]   rem_dec;
    logic [CNT_W-1:0]   len;
    logic [WC_W-1:0]    nb;

    assign accept    = word_vld & word_rdy;
    assign pop       = byte_vld & byte_rdy;
    assign word_end  = pop & (wcnt == WC_W'(1));
    assign frame_end = pop & byte_last;
    assign word_rdy  = !byte_vld | word_end;
    assign byte_o    = sreg[7:0];

    // A frame finishing this very cycle lets the next word start a new frame.
    assign eff_idle = (state == IDLE) | frame_end;
    assign start    = accept & word_first & (num_bytes_i != '0);
    assign cont     = accept & !word_first & !eff_idle;
    assign kill     = accept & word_first & (num_bytes_i == '0);
    assign load     = start | cont;

    assign rem_dec = (pop && remaining != '0) ? remaining - CNT_W'(1) : remaining;
    assign len     = start ? num_bytes_i : rem_dec;
    assign nb      = (len > BPW_C) ? WC_W'(BPW) : WC_W'(len);
    assign forced  = word_last & (len > BPW_C);

    assign err_now = (accept & !word_first & eff_idle)
                   | kill
                   | (accept & word_first & !eff_idle)
                   | (load & (word_last ? (len > BPW_C) : (len <= BPW_C)));

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end else if (frame_end) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            sreg       <= '0;
            wcnt       <= '0;
            remaining  <= '0;
            force_last <= 1'b0;
            byte_vld   <= 1'b0;
            byte_first <= 1'b0;
            byte_last  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load) begin
                sreg       <= word_i;
                wcnt       <= nb;
                remaining  <= len;
                force_last <= forced;
                byte_vld   <= 1'b1;
                byte_first <= start;
                byte_last  <= (len == CNT_W'(1)) | (forced & (nb == WC_W'(1)));
            end else if (kill) begin
                wcnt       <= '0;
                remaining  <= '0;
                force_last <= 1'b0;
                byte_vld   <= 1'b0;
                byte_first <= 1'b0;
                byte_last  <= 1'b0;
            end else if (pop) begin
                remaining  <= frame_end ? '0 : rem_dec;
                byte_first <= 1'b0;
                if (wcnt > WC_W'(1)) begin
                    sreg      <= sreg >> 8;
                    wcnt      <= wcnt - WC_W'(1);
                    byte_last <= (rem_dec == CNT_W'(1)) | (force_last & (wcnt == WC_W'(2)));
                end else begin
                    wcnt       <= '0;
                    force_last <= 1'b0;
                    byte_vld   <= 1'b0;
                    byte_last  <= 1'b0;
                end
            end
            frame_done <= frame_end;
            frame_err  <= err_now;
        end
    end

endmodule

// File: tb/tb_series_result_unpacker.sv
// Directed and randomized bench for series_result_unpacker with a byte-list
// reference model built from frame length and word contents.
module tb_series_result_unpacker;

    logic        clk = 1'b0;
    logic        rst_p;
    logic [15:0] num_bytes_i;
    logic [31:0] word_i;
    logic        word_first;
    logic        word_last;
    logic        word_vld;
    logic        word_rdy;
    logic [7:0]  byte_o;
    logic        byte_first;
    logic        byte_last;
    logic        byte_vld;
    logic        byte_rdy;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int pat_idx = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_pop_cyc = -10;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int pop_cyc_q[$];
    bit prev_stall = 1'b0;
    bit prev_rst = 1'b1;
    logic [9:0] prev_bits = '0;

    series_result_unpacker dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .num_bytes_i (num_bytes_i),
        .word_i      (word_i),
        .word_first  (word_first),
        .word_last   (word_last),
        .word_vld    (word_vld),
        .word_rdy    (word_rdy),
        .byte_o      (byte_o),
        .byte_first  (byte_first),
        .byte_last   (byte_last),
        .byte_vld    (byte_vld),
        .byte_rdy    (byte_rdy),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer ready: 0 always, 1 pattern 1,0,0,1,0, 2 random, else stalled.
    initial begin
        byte_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: byte_rdy = 1'b1;
                1: begin
                    byte_rdy = (pat_idx % 5 == 0) || (pat_idx % 5 == 3);
                    pat_idx++;
                end
                2: byte_rdy = 1'($urandom_range(0, 1));
                default: byte_rdy = 1'b0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (byte_vld && byte_rdy) begin
            got_q.push_back({byte_first, byte_last, byte_o});
            pop_cyc_q.push_back(cyc);
            if (byte_last) last_pop_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            chk("done_timing", cyc, last_pop_cyc + 1);
        end
        if (frame_err) err_cnt++;
        if (prev_stall && !prev_rst) begin
            chk("stall_vld", byte_vld, 1);
            chk("stall_data", {byte_first, byte_last, byte_o}, prev_bits);
        end
        prev_stall = byte_vld && !byte_rdy;
        prev_rst   = rst_p;
        prev_bits  = {byte_first, byte_last, byte_o};
    end

    task automatic ep(input logic f, input logic l, input logic [7:0] b);
        exp_q.push_back({f, l, b});
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic f, input logic l,
                             input logic [15:0] n, output int acc);
        bit ok = 1'b0;
        word_i = w; word_first = f; word_last = l; num_bytes_i = n; word_vld = 1'b1;
        acc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (word_rdy) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        word_vld = 1'b0; word_first = 1'b0; word_last = 1'b0;
        chk("word_accept_timeout", 32'(ok), 1);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && got_q.size() < target; i++) @(negedge clk);
        chk(tag, 32'(got_q.size() >= target), 1);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
        got_q.delete(); exp_q.delete(); pop_cyc_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_word_rdy"}, word_rdy, 1);
        chk({tag, "_byte_vld"}, byte_vld, 0);
        chk({tag, "_byte_first"}, byte_first, 0);
        chk({tag, "_byte_last"}, byte_last, 0);
        chk({tag, "_byte_o"}, byte_o, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        int a0, a1, base, d0, e0, total, nbytes, nw, g;
        logic [31:0] words[3];

        rst_p = 1'b1; word_vld = 1'b0; word_i = '0; word_first = 1'b0;
        word_last = 1'b0; num_bytes_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        align();
        rst_p = 1'b0;

        // Single-word frame
        d0 = done_cnt; e0 = err_cnt;
        ep(1, 0, 8'h11); ep(0, 0, 8'h22); ep(0, 0, 8'h33); ep(0, 1, 8'h44);
        send_word(32'h44332211, 1, 1, 16'd4, a0);
        chk("t1_latency_vld", byte_vld, 1);
        chk("t1_first_byte", {byte_first, byte_last, byte_o}, {1'b1, 1'b0, 8'h11});
        wait_bytes("t1_timeout", 4, 100);
        settle(3);
        check_stream("t1");
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_cnt - e0, 0);
        chk("t1_busy", busy, 0);

        // Two words, partial final word, no bubble between words
        align();
        d0 = done_cnt; e0 = err_cnt; base = got_q.size();
        ep(1, 0, 8'h11); ep(0, 0, 8'h22); ep(0, 0, 8'h33); ep(0, 0, 8'h44);
        ep(0, 0, 8'h55); ep(0, 1, 8'h66);
        send_word(32'h44332211, 1, 0, 16'd6, a0);
        send_word(32'hAABB6655, 0, 1, 16'd6, a1);
        chk("t2_no_bubble", a1 - a0, 4);
        chk("t2_reload_at_final_pop", got_q.size() - base, 4);
        wait_bytes("t2_timeout", 6, 100);
        settle(3);
        check_stream("t2");
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_err", err_cnt - e0, 0);

        // Backpressure pattern
        align();
        rdy_mode = 1; pat_idx = 0;
        d0 = done_cnt; e0 = err_cnt; base = got_q.size();
        for (int i = 0; i < 8; i++)
            ep(i == 0, i == 7, (i < 4) ? 8'(8'h0A + i) : 8'(8'h1A + i - 4));
        send_word(32'h0D0C0B0A, 1, 0, 16'd8, a0);
        send_word(32'h1D1C1B1A, 0, 1, 16'd8, a1);
        chk("t3_rdy_low_until_final_pop", got_q.size() - base, 4);
        wait_bytes("t3_timeout", 8, 200);
        settle(3);
        check_stream("t3");
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_err", err_cnt - e0, 0);
        rdy_mode = 0;

        // Word without first while idle
        align();
        e0 = err_cnt;
        send_word(32'hDEADBEEF, 0, 1, 16'd4, a0);
        settle(4);
        chk("t4a_dropped", got_q.size(), 0);
        chk("t4a_err", err_cnt - e0, 1);
        chk("t4a_busy", busy, 0);

        // Zero-length frame
        align();
        e0 = err_cnt;
        send_word(32'h00000055, 1, 1, 16'd0, a0);
        settle(4);
        chk("t4d_dropped", got_q.size(), 0);
        chk("t4d_err", err_cnt - e0, 1);
        chk("t4d_busy", busy, 0);

        // Early word_last forces the end of frame
        align();
        d0 = done_cnt; e0 = err_cnt;
        ep(1, 0, 8'h01); ep(0, 0, 8'h02); ep(0, 0, 8'h03); ep(0, 1, 8'h04);
        send_word(32'h04030201, 1, 1, 16'd8, a0);
        wait_bytes("t4b_timeout", 4, 100);
        settle(3);
        check_stream("t4b");
        chk("t4b_err", err_cnt - e0, 1);
        chk("t4b_done", done_cnt - d0, 1);
        chk("t4b_busy", busy, 0);

        // New first word in the middle of a frame aborts it
        align();
        d0 = done_cnt; e0 = err_cnt;
        ep(1, 0, 8'h11); ep(0, 0, 8'h12); ep(0, 0, 8'h13); ep(0, 0, 8'h14);
        ep(1, 0, 8'h21); ep(0, 0, 8'h22); ep(0, 0, 8'h23); ep(0, 1, 8'h24);
        send_word(32'h14131211, 1, 0, 16'd8, a0);
        send_word(32'h24232221, 1, 1, 16'd4, a1);
        wait_bytes("t4c_timeout", 8, 100);
        settle(3);
        check_stream("t4c");
        chk("t4c_err", err_cnt - e0, 1);
        chk("t4c_done", done_cnt - d0, 1);

        // Back-to-back frames of 5 and 3 bytes
        align();
        d0 = done_cnt; e0 = err_cnt;
        pop_cyc_q.delete();
        ep(1, 0, 8'h31); ep(0, 0, 8'h32); ep(0, 0, 8'h33); ep(0, 0, 8'h34); ep(0, 1, 8'h35);
        ep(1, 0, 8'h41); ep(0, 0, 8'h42); ep(0, 1, 8'h43);
        send_word(32'h34333231, 1, 0, 16'd5, a0);
        send_word(32'h00000035, 0, 1, 16'd5, a0);
        send_word(32'h00434241, 1, 1, 16'd3, a0);
        wait_bytes("t5_timeout", 8, 100);
        settle(3);
        chk("t5_contiguous", pop_cyc_q[pop_cyc_q.size() - 1] - pop_cyc_q[0], 7);
        check_stream("t5");
        chk("t5_done", done_cnt - d0, 2);
        chk("t5_err", err_cnt - e0, 0);

        // Reset in the middle of a frame
        align();
        send_word(32'h64636261, 1, 0, 16'd8, a0);
        align();
        align();
        rst_p = 1'b1;
        rdy_mode = 3;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t6_midreset");
        align();
        rst_p = 1'b0;
        rdy_mode = 0;
        got_q.delete(); exp_q.delete(); pop_cyc_q.delete();
        settle(1);
        align();
        d0 = done_cnt; e0 = err_cnt;
        ep(1, 0, 8'h71); ep(0, 0, 8'h72); ep(0, 1, 8'h73);
        send_word(32'h00737271, 1, 1, 16'd3, a0);
        wait_bytes("t6_timeout", 3, 100);
        settle(3);
        check_stream("t6");
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_err", err_cnt - e0, 0);

        // Random well-formed frames under random backpressure
        align();
        rdy_mode = 2;
        d0 = done_cnt; e0 = err_cnt; total = 0;
        for (int f = 0; f < 20; f++) begin
            nbytes = $urandom_range(1, 12);
            nw = (nbytes + 3) / 4;
            for (int k = 0; k < 3; k++) words[k] = $urandom;
            for (int i = 0; i < nbytes; i++)
                ep(i == 0, i == nbytes - 1, 8'(words[i / 4] >> (8 * (i % 4))));
            total += nbytes;
            for (int k = 0; k < nw; k++) begin
                send_word(words[k], k == 0, k == nw - 1, 16'(nbytes), a0);
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        wait_bytes("t7_timeout", total, 3000);
        settle(4);
        check_stream("t7");
        chk("t7_done", done_cnt - d0, 20);
        chk("t7_err", err_cnt - e0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
